soc_system_clkgen_multi: RTL and testbench

Parametrised multi-output clock generator built from one reference clock using programmable integer dividers. Each channel has its own divide ratio, high time (duty), phase offset and enable. Channels are reprogrammed at runtime through a valid/ready config port, and every change takes effect glitch-free at the channel's period boundary. The block sits beside the SoC PLL outputs and supplies derived low-rate clocks/strobes plus a `locked` indication to fabric logic.

---
 rtl/soc_system_clkgen_multi.sv | 157 +++++++++++++++
 tb/tb_soc_system_clkgen_multi.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_clkgen_multi
// Brief    : Multi-channel integer clock divider with glitch-free runtime
//            reprogramming and a lock indication.
// Revision : 1.0
// ============================================================================
module soc_system_clkgen_multi #(
  parameter int NUM_CLOCKS  = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int CHAN_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic [CNT_WIDTH-1:0]  cfg_high,
  input  logic [CNT_WIDTH-1:0]  cfg_phase,
  input  logic                  cfg_enable,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int                   c_lock_w    = $clog2(LOCK_CYCLES + 1);
  localparam logic [c_lock_w-1:0]  c_lock_last = c_lock_w'(LOCK_CYCLES - 1);
  localparam logic [c_lock_w-1:0]  c_lock_one  = c_lock_w'(1);
  localparam logic [CNT_WIDTH-1:0] c_zero      = '0;
  localparam logic [CNT_WIDTH-1:0] c_one       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_two       = CNT_WIDTH'(2);

  localparam logic [1:0] S_RESET_LOCK = 2'd0;
  localparam logic [1:0] S_IDLE       = 2'd1;
  localparam logic [1:0] S_WAIT_WRAP  = 2'd2;
  localparam logic [1:0] S_LOCKING    = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [c_lock_w-1:0]   r_lock_cnt;
  logic                  w_lock_done;
  logic                  w_accept;
  logic                  w_chan_ok;
  logic [NUM_CLOCKS-1:0] w_commit;

  logic [CNT_WIDTH-1:0]  w_div_san;
  logic [CNT_WIDTH-1:0]  w_phase_san;
  logic [CNT_WIDTH-1:0]  w_reload_san;

  logic [CHAN_W-1:0]     r_sh_chan;
  logic [CNT_WIDTH-1:0]  r_sh_div;
  logic [CNT_WIDTH-1:0]  r_sh_high;
  logic [CNT_WIDTH-1:0]  r_sh_reload;
  logic                  r_sh_en;

  // Sanitise on accept; the phase is folded into the counter reload value.
  assign w_div_san    = (cfg_div < c_two) ? c_two : cfg_div;
  assign w_phase_san  = (cfg_phase >= w_div_san) ? c_zero : cfg_phase;
  assign w_reload_san = (w_phase_san == c_zero) ? c_zero : (w_div_san - w_phase_san);
  assign w_chan_ok    = (32'(cfg_chan) < 32'(NUM_CLOCKS));
  assign w_accept     = (r_state == S_IDLE) && cfg_valid;
  assign w_lock_done  = (r_lock_cnt == c_lock_last);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_chan   <= '0;
      r_sh_div    <= c_two;
      r_sh_high   <= c_one;
      r_sh_reload <= c_zero;
      r_sh_en     <= 1'b1;
    end else if (w_accept) begin
      r_sh_chan   <= cfg_chan;
      r_sh_div    <= w_div_san;
      r_sh_high   <= cfg_high;
      r_sh_reload <= w_reload_san;
      r_sh_en     <= cfg_enable;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET_LOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET_LOCK: if (w_lock_done) w_state_nxt = S_IDLE;
      S_IDLE:       if (w_accept)    w_state_nxt = w_chan_ok ? S_WAIT_WRAP : S_LOCKING;
      S_WAIT_WRAP:  if (|w_commit)   w_state_nxt = S_LOCKING;
      S_LOCKING:    if (w_lock_done) w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_RESET_LOCK;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    locked    = 1'b0;
    if (r_state == S_IDLE) begin
      cfg_ready = 1'b1;
      locked    = 1'b1;
    end
  end

  // Lock counter only runs while settling; it restarts from zero on each entry.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
    end else if ((r_state == S_RESET_LOCK) || (r_state == S_LOCKING)) begin
      r_lock_cnt <= w_lock_done ? '0 : (r_lock_cnt + c_lock_one);
    end else begin
      r_lock_cnt <= '0;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    logic [CNT_WIDTH-1:0] r_div;
    logic [CNT_WIDTH-1:0] r_high;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_en;
    logic                 r_out;

    // Commit only at the last count of the old period, so it always completes.
    assign w_commit[i] = (r_state == S_WAIT_WRAP) && (r_sh_chan == CHAN_W'(i)) &&
                         (!r_en || (r_cnt == (r_div - c_one)));

    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        r_div  <= c_two;
        r_high <= c_one;
        r_en   <= 1'b1;
        r_cnt  <= c_zero;
        r_out  <= 1'b0;
      end else begin
        r_out <= r_en && (r_cnt < r_high);
        if (w_commit[i]) begin
          r_div  <= r_sh_div;
          r_high <= r_sh_high;
          r_en   <= r_sh_en;
          r_cnt  <= r_sh_reload;
        end else if (r_cnt >= (r_div - c_one)) begin
          r_cnt  <= c_zero;
        end else begin
          r_cnt  <= r_cnt + c_one;
        end
      end
    end

    assign outclk[i] = r_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_clkgen_multi
// Brief    : Scoreboard bench for soc_system_clkgen_multi against a closed-form
//            per-edge reference model.
// Revision : 1.0
// ============================================================================
module tb_soc_system_clkgen_multi;

  localparam int NCLK = 4;
  localparam int CW   = 16;
  localparam int LC   = 16;
  localparam int CHW  = 3;

  logic            refclk = 1'b0;
  logic            rst_n  = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_chan  = '0;
  logic [CW-1:0]   cfg_div   = '0;
  logic [CW-1:0]   cfg_high  = '0;
  logic [CW-1:0]   cfg_phase = '0;
  logic            cfg_enable = 1'b0;
  logic [NCLK-1:0] outclk;
  logic            locked;

  soc_system_clkgen_multi #(
    .NUM_CLOCKS (NCLK),
    .CNT_WIDTH  (CW),
    .LOCK_CYCLES(LC),
    .CHAN_W     (CHW)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .cfg_enable(cfg_enable),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [NCLK-1:0] oc;
    logic            lk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: each channel's count at edge k is (k - t0) mod div.
  int m_div [NCLK];
  int m_high[NCLK];
  int m_t0  [NCLK];
  bit m_en  [NCLK];
  int m_k, m_lock_at;
  bit m_pend;
  int m_pchan, m_pdiv, m_phigh, m_pphase;
  bit m_pen;

  function automatic int pmod(int x, int d);
    return ((x % d) + d) % d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCLK; i++) begin
      m_div[i] = 2; m_high[i] = 1; m_en[i] = 1'b1; m_t0[i] = 1;
    end
    m_k = 0;
    m_lock_at = LC;
    m_pend = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    exp_t e;
    bit   ready_now;
    int   d, p, c;
    m_k++;
    ready_now = ((m_k - 1) >= m_lock_at) && !m_pend;
    for (int i = 0; i < NCLK; i++)
      e.oc[i] = m_en[i] && (pmod(m_k - m_t0[i], m_div[i]) < m_high[i]);
    if (m_pend) begin
      c = m_pchan;
      if (!m_en[c] || pmod(m_k - m_t0[c], m_div[c]) == m_div[c] - 1) begin
        m_div[c]  = m_pdiv;
        m_high[c] = m_phigh;
        m_en[c]   = m_pen;
        m_t0[c]   = m_k + 1 - ((m_pphase == 0) ? 0 : (m_pdiv - m_pphase));
        m_pend    = 1'b0;
        m_lock_at = m_k + LC;
      end
    end else if (ready_now && cfg_valid) begin
      d = int'(cfg_div);
      if (d < 2) d = 2;
      p = int'(cfg_phase);
      if (p >= d) p = 0;
      if (int'(cfg_chan) < NCLK) begin
        m_pend = 1'b1; m_pchan = int'(cfg_chan); m_pdiv = d;
        m_phigh = int'(cfg_high); m_pphase = p; m_pen = cfg_enable;
        m_lock_at = 1 << 30;
      end else begin
        m_lock_at = m_k + LC;
      end
    end
    e.lk = (m_k >= m_lock_at);
    exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (outclk !== e.oc || locked !== e.lk || cfg_ready !== e.lk) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got outclk=%b locked=%b ready=%b, want outclk=%b locked=%b ready=%b",
                   $time, outclk, locked, cfg_ready, e.oc, e.lk, e.lk);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!cfg_ready && t < 300) begin
      @(negedge refclk);
      t++;
    end
    if (!cfg_ready) chk("ready_timeout", 32'(cfg_ready), 32'd1);
  endtask

  task automatic do_write(input int ch, input int dv, input int hi, input int ph, input bit en);
    wait_ready();
    cfg_valid  = 1'b1;
    cfg_chan   = CHW'(ch);
    cfg_div    = CW'(dv);
    cfg_high   = CW'(hi);
    cfg_phase  = CW'(ph);
    cfg_enable = en;
    @(negedge refclk);
    cfg_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge refclk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    chk("reset_outclk", 32'(outclk), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_ready",  32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    idle(2);

    do_write(1, 5, 2, 0, 1'b1);  idle(12);
    do_write(2, 4, 2, 1, 1'b1);  idle(10);
    do_write(0, 0, 1, 0, 1'b1);  idle(6);
    do_write(3, 6, 0, 0, 1'b1);  idle(8);
    do_write(1, 5, 7, 0, 1'b1);  idle(8);
    do_write(2, 5, 2, 9, 1'b1);  idle(10);
    do_write(7, 3, 1, 0, 1'b1);  idle(4);
    do_write(3, 4, 2, 0, 1'b0);  idle(6);
    do_write(3, 3, 1, 0, 1'b1);  idle(9);

    for (int n = 0; n < 30; n++) begin
      do_write($urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 10),
               $urandom_range(0, 10), ($urandom_range(0, 3) != 0));
      idle($urandom_range(0, 12));
    end

    // Asynchronous reset while a commit is pending on a slow channel.
    do_write(1, 9, 4, 0, 1'b1);
    wait_ready();
    cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_div = 16'd3; cfg_high = 16'd2;
    cfg_phase = 16'd0; cfg_enable = 1'b1;
    @(negedge refclk);
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_outclk", 32'(outclk), 32'd0);
    chk("async_locked", 32'(locked), 32'd0);
    chk("async_ready",  32'(cfg_ready), 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(40);
    do_write(0, 3, 1, 2, 1'b1);
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
